// File: rtl/mcbsp0_slave_rx_if.sv
// Bus bundle for the McBSP receive slave: DSP serial pins, frame configuration,
// and the parallel word/strobe outputs.
interface mcbsp0_slave_rx_if;
  logic        mcbsp_rx_en;
  logic [8:0]  mcbsp_reg_number;
  logic [6:0]  mcbsp_reg_length;
  logic        mcbsp_slave_clkx;
  logic        mcbsp_slave_fsx;
  logic        mcbsp_slave_mosi;
  logic [31:0] mcbsp_data_out;
  logic        mcbsp_data_valid;
  logic [8:0]  mcbsp_word_index;
  logic        mcbsp_frame_done;
  logic        mcbsp_fs_err;
  logic        mcbsp_len_err;
  logic        mcbsp_timeout_err;
  logic [63:0] debug_signal;

  modport master (
    output mcbsp_rx_en, mcbsp_reg_number, mcbsp_reg_length,
           mcbsp_slave_clkx, mcbsp_slave_fsx, mcbsp_slave_mosi,
    input  mcbsp_data_out, mcbsp_data_valid, mcbsp_word_index, mcbsp_frame_done,
           mcbsp_fs_err, mcbsp_len_err, mcbsp_timeout_err, debug_signal
  );

  modport slave (
    input  mcbsp_rx_en, mcbsp_reg_number, mcbsp_reg_length,
           mcbsp_slave_clkx, mcbsp_slave_fsx, mcbsp_slave_mosi,
    output mcbsp_data_out, mcbsp_data_valid, mcbsp_word_index, mcbsp_frame_done,
           mcbsp_fs_err, mcbsp_len_err, mcbsp_timeout_err, debug_signal
  );
endinterface

// File: rtl/mcbsp0_slave_rx.sv
// McBSP receive slave: oversamples DSP CLKX/FSX/DX and emits MSB-first words.
// Define MCBSP_RX_FS_RESYNC_EN to make an early FS restart the current word.
module mcbsp0_slave_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input logic              mcbsp_clk_in,
  input logic              mcbsp_rst_in,
  mcbsp0_slave_rx_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2} state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] clkx_sync, fsx_sync, mosi_sync;
  logic clkx_s, fsx_s, mosi_s, clkx_d;
  logic evt_p1, fsx_p1, mosi_p1;
  logic [DATA_W-1:0] shreg, shreg_n, sh_next, data_q, data_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [8:0]  word_cnt, word_cnt_n, num_l, num_l_n, idx_q, idx_n;
  logic [6:0]  len_l, len_l_n;
  logic [15:0] idle_cnt;
  logic vld_q, vld_n, done_q, done_n, fserr_q, fserr_n;
  logic lenerr_q, lenerr_n, toerr_q, toerr_n;
  logic last_bit, len_ok, timeout_hit, fs_start;

  assign clkx_s = clkx_sync[SYNC_STAGES-1];
  assign fsx_s  = fsx_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Stage p0: pin synchronizers; stage p1: registered sample event with its fsx/mosi
  always_ff @(posedge mcbsp_clk_in) begin
    if (!mcbsp_rst_in) begin
      clkx_sync <= '0;
      fsx_sync  <= '0;
      mosi_sync <= '0;
      clkx_d    <= 1'b0;
      evt_p1    <= 1'b0;
      fsx_p1    <= 1'b0;
      mosi_p1   <= 1'b0;
    end else begin
      clkx_sync <= {clkx_sync[SYNC_STAGES-2:0], bus.mcbsp_slave_clkx};
      fsx_sync  <= {fsx_sync[SYNC_STAGES-2:0], bus.mcbsp_slave_fsx};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mcbsp_slave_mosi};
      clkx_d    <= clkx_s;
      evt_p1    <= clkx_d & ~clkx_s;
      fsx_p1    <= fsx_s;
      mosi_p1   <= mosi_s;
    end
  end

  always_ff @(posedge mcbsp_clk_in) begin
    if (!mcbsp_rst_in || !bus.mcbsp_rx_en || (clkx_d ^ clkx_s))
      idle_cnt <= '0;
    else if (idle_cnt != 16'(IDLE_TIMEOUT))
      idle_cnt <= idle_cnt + 16'd1;
  end

  // IDLE with word_cnt != 0 is the between-words wait inside a frame
  assign timeout_hit = (idle_cnt == 16'(IDLE_TIMEOUT)) &&
                       ((state != IDLE) || (word_cnt != 9'd0));
  assign sh_next  = {shreg[DATA_W-2:0], mosi_p1};
  assign last_bit = ({1'b0, bit_cnt} == (len_l - 7'd1));
  assign len_ok   = (bus.mcbsp_reg_length != 7'd0) && (bus.mcbsp_reg_length <= 7'd32);

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    len_l_n    = len_l;
    num_l_n    = num_l;
    data_n     = data_q;
    idx_n      = idx_q;
    vld_n      = 1'b0;
    done_n     = 1'b0;
    fserr_n    = 1'b0;
    lenerr_n   = 1'b0;
    toerr_n    = 1'b0;
    fs_start   = 1'b0;
    if (!bus.mcbsp_rx_en) begin
      state_n    = IDLE;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end else if (timeout_hit) begin
      toerr_n    = 1'b1;
      state_n    = IDLE;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end else if (evt_p1) begin
      if (state == IDLE) begin
        fs_start = fsx_p1;
      end else if (last_bit) begin
        vld_n     = 1'b1;
        data_n    = sh_next;
        idx_n     = word_cnt;
        shreg_n   = '0;
        bit_cnt_n = '0;
        state_n   = IDLE;
        fs_start  = fsx_p1;
        if (word_cnt == num_l) begin
          done_n     = 1'b1;
          word_cnt_n = '0;
        end else begin
          word_cnt_n = word_cnt + 9'd1;
        end
      end else begin
        shreg_n   = sh_next;
        bit_cnt_n = bit_cnt + 6'd1;
        state_n   = SHIFT;
        if (fsx_p1) begin
          fserr_n = 1'b1;
`ifdef MCBSP_RX_FS_RESYNC_EN
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = ARMED;
`endif
        end
      end
      if (fs_start) begin
        if (len_ok) begin
          len_l_n   = bus.mcbsp_reg_length;
          num_l_n   = bus.mcbsp_reg_number;
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = ARMED;
        end else begin
          lenerr_n = 1'b1;
          state_n  = IDLE;
        end
      end
    end
  end

  // Stage p2: FSM state, datapath and output strobes
  always_ff @(posedge mcbsp_clk_in) begin
    if (!mcbsp_rst_in) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len_l    <= '0;
      num_l    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      fserr_q  <= 1'b0;
      lenerr_q <= 1'b0;
      toerr_q  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      word_cnt <= word_cnt_n;
      len_l    <= len_l_n;
      num_l    <= num_l_n;
      data_q   <= data_n;
      idx_q    <= idx_n;
      vld_q    <= vld_n;
      done_q   <= done_n;
      fserr_q  <= fserr_n;
      lenerr_q <= lenerr_n;
      toerr_q  <= toerr_n;
    end
  end

  assign bus.mcbsp_data_out    = data_q;
  assign bus.mcbsp_data_valid  = vld_q;
  assign bus.mcbsp_word_index  = idx_q;
  assign bus.mcbsp_frame_done  = done_q;
  assign bus.mcbsp_fs_err      = fserr_q;
  assign bus.mcbsp_len_err     = lenerr_q;
  assign bus.mcbsp_timeout_err = toerr_q;
  assign bus.debug_signal = {state, bit_cnt, word_cnt, idle_cnt, len_l, num_l,
                             clkx_s, fsx_s, mosi_s, evt_p1, 11'd0};
endmodule

// File: tb/tb_mcbsp0_slave_rx.sv
// Directed bench for mcbsp0_slave_rx: drives DSP-side serial frames and
// checks received words, strobes and reset behaviour against hand values.
module tb_mcbsp0_slave_rx;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcbsp0_slave_rx_if bus();

  mcbsp0_slave_rx #(.SYNC_STAGES(2), .IDLE_TIMEOUT(255)) dut (
    .mcbsp_clk_in (clk),
    .mcbsp_rst_in (rst_n),
    .bus          (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] vdata [64];
  logic [8:0]  vidx  [64];
  logic        vdone [64];
  int vcnt = 0, dcnt = 0, fscnt = 0, lencnt = 0, tocnt = 0, lone_done = 0;

  always @(negedge clk) begin
    if (bus.mcbsp_data_valid) begin
      vdata[vcnt % 64] <= bus.mcbsp_data_out;
      vidx[vcnt % 64]  <= bus.mcbsp_word_index;
      vdone[vcnt % 64] <= bus.mcbsp_frame_done;
      vcnt <= vcnt + 1;
    end
    if (bus.mcbsp_frame_done) dcnt <= dcnt + 1;
    if (bus.mcbsp_frame_done && !bus.mcbsp_data_valid) lone_done <= lone_done + 1;
    if (bus.mcbsp_fs_err) fscnt <= fscnt + 1;
    if (bus.mcbsp_len_err) lencnt <= lencnt + 1;
    if (bus.mcbsp_timeout_err) tocnt <= tocnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sbit(input logic fs, input logic d);
    bus.mcbsp_slave_clkx = 1'b1;
    bus.mcbsp_slave_fsx  = fs;
    bus.mcbsp_slave_mosi = d;
    repeat (HALF) @(negedge clk);
    bus.mcbsp_slave_clkx = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends the first nbits data bits of a len-bit word, MSB first
  task automatic send_word(input logic [31:0] w, input int len, input bit lead_fs,
                           input bit last_fs, input int early, input int nbits);
    if (lead_fs) sbit(1'b1, 1'b0);
    for (int k = 0; k < nbits; k++)
      sbit((k == early) || ((k == len - 1) && last_fs), w[len-1-k]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic cfg(input int len, input int num);
    bus.mcbsp_reg_length = 7'(len);
    bus.mcbsp_reg_number = 9'(num);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  64'(bus.mcbsp_data_out), 64'd0);
    chk({tag, "_valid"}, 64'(bus.mcbsp_data_valid), 64'd0);
    chk({tag, "_index"}, 64'(bus.mcbsp_word_index), 64'd0);
    chk({tag, "_strobes"}, 64'({bus.mcbsp_frame_done, bus.mcbsp_fs_err,
                               bus.mcbsp_len_err, bus.mcbsp_timeout_err}), 64'd0);
    chk({tag, "_debug"}, bus.debug_signal, 64'd0);
  endtask

  initial begin
    int base, fs0, len0, to0, n;
    bus.mcbsp_rx_en      = 1'b1;
    bus.mcbsp_slave_clkx = 1'b0;
    bus.mcbsp_slave_fsx  = 1'b0;
    bus.mcbsp_slave_mosi = 1'b0;
    cfg(32, 0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    settle();

    // 32-bit single-word frame
    base = vcnt;
    send_word(32'hA5C3_0F81, 32, 1, 0, -1, 32);
    settle();
    chk("w32_count", 64'(vcnt - base), 64'd1);
    chk("w32_data",  64'(vdata[base % 64]), 64'hA5C3_0F81);
    chk("w32_index", 64'(vidx[base % 64]), 64'd0);
    chk("w32_done",  64'(vdone[base % 64]), 64'd1);

    // three back-to-back 8-bit words
    cfg(8, 2);
    base = vcnt;
    send_word(32'h12, 8, 1, 1, -1, 8);
    send_word(32'h34, 8, 0, 1, -1, 8);
    send_word(32'h56, 8, 0, 0, -1, 8);
    settle();
    chk("b2b_count", 64'(vcnt - base), 64'd3);
    chk("b2b_data0", 64'(vdata[base % 64]), 64'h12);
    chk("b2b_data1", 64'(vdata[(base + 1) % 64]), 64'h34);
    chk("b2b_data2", 64'(vdata[(base + 2) % 64]), 64'h56);
    chk("b2b_idx",   64'({vidx[base % 64], vidx[(base + 1) % 64], vidx[(base + 2) % 64]}),
        64'({9'd0, 9'd1, 9'd2}));
    chk("b2b_done",  64'({vdone[base % 64], vdone[(base + 1) % 64], vdone[(base + 2) % 64]}),
        64'b001);

    // early FS on data bit 5 of a 16-bit word
    cfg(16, 0);
    base = vcnt;
    fs0 = fscnt;
`ifdef MCBSP_RX_FS_RESYNC_EN
    send_word(32'hBEEF, 16, 1, 0, 5, 6);
    send_word(32'h1357, 16, 0, 0, -1, 16);
    settle();
    chk("efs_data", 64'(vdata[base % 64]), 64'h1357);
`else
    send_word(32'hBEEF, 16, 1, 0, 5, 16);
    settle();
    chk("efs_data", 64'(vdata[base % 64]), 64'hBEEF);
`endif
    chk("efs_count",  64'(vcnt - base), 64'd1);
    chk("efs_fs_err", 64'(fscnt - fs0), 64'd1);

    // illegal lengths at FS
    base = vcnt;
    len0 = lencnt;
    cfg(0, 0);
    send_word(32'hFF, 8, 1, 0, -1, 8);
    cfg(40, 0);
    send_word(32'hFF, 8, 1, 0, -1, 8);
    settle();
    chk("len_err_count", 64'(lencnt - len0), 64'd2);
    chk("len_no_valid",  64'(vcnt - base), 64'd0);

    // clkx stops mid-frame after word 1
    cfg(8, 3);
    base = vcnt;
    to0 = tocnt;
    send_word(32'hC1, 8, 1, 1, -1, 8);
    send_word(32'h7E, 8, 0, 0, -1, 8);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (bus.mcbsp_timeout_err) break;
    end
    chk("to_cycle", 64'(n), 64'd255);
    repeat (60) @(negedge clk);
    chk("to_count",   64'(tocnt - to0), 64'd1);
    chk("to_valids",  64'(vcnt - base), 64'd2);
    chk("to_idx1",    64'(vidx[(base + 1) % 64]), 64'd1);
    cfg(8, 0);
    send_word(32'h5A, 8, 1, 0, -1, 8);
    settle();
    chk("to_next_data", 64'(vdata[(base + 2) % 64]), 64'h5A);
    chk("to_next_idx",  64'(vidx[(base + 2) % 64]), 64'd0);

    // one-cycle reset in the middle of a word
    cfg(16, 0);
    base = vcnt;
    send_word(32'hFFFF, 16, 1, 0, -1, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1;
    settle();
    send_word(32'h6A5C, 16, 1, 0, -1, 16);
    settle();
    chk("midrst_count", 64'(vcnt - base), 64'd1);
    chk("midrst_data",  64'(vdata[base % 64]), 64'h6A5C);
    chk("done_with_valid", 64'(lone_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
